// File: rtl/rom_arbiter.sv
// ---------------------------------------------------------------------------
// rom_arbiter
// Shares one synchronous ROM port between two requesters. An idle arbiter
// grants combinationally, so a grant and its address sample happen in the
// same cycle. The read is then issued, waited out for ROM_LAT cycles and
// captured into rdata. Only one read is in flight at a time.
//
// Ports
//   sys_clk    : single clock, all state on the rising edge
//   rst        : asynchronous active-high reset
//   req0/req1  : read requests, held high until the matching gnt
//   addr0/1    : word addresses, stable while the request is high
//   gnt0/gnt1  : one-cycle pulse, request accepted and address sampled
//   vld0/vld1  : one-cycle pulse, rdata holds that requester's result
//   rdata      : registered read result shared by both requesters
//   busy       : high whenever an access is in flight (state not IDLE)
//   rom_ena    : registered ROM enable, high for exactly one cycle per read
//   rom_addra  : registered ROM address, holds while rom_ena is low
//   rom_douta  : ROM read data, valid ROM_LAT cycles after the enable
// ---------------------------------------------------------------------------
module rom_arbiter #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 16,
   parameter int ROM_LAT = 1
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              gnt0,
   output logic              vld0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt1,
   output logic              vld1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              rom_ena,
   output logic [ADDR_W-1:0] rom_addra,
   input  logic [DATA_W-1:0] rom_douta
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   localparam logic [1:0] LAT_LOAD = 2'(ROM_LAT - 1);

   state_t              r_state;
   state_t              w_nextState;
   logic [1:0]          r_count;
   logic                r_owner;
   logic                r_lastServed;
   logic                r_romEna;
   logic [ADDR_W-1:0]   r_romAddr;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_vld0;
   logic                r_vld1;
   logic                w_anyReq;
   logic                w_winner;
   logic                w_grant;

   // Arbitration. A lone requester always wins; on a tie the requester that
   // was not served last wins. Requests are masked while rst is high so no
   // grant can be issued during reset.
   always_comb begin
      w_anyReq = (req0 | req1) & ~rst;
      w_winner = (req0 & req1) ? ~r_lastServed : req1;
      w_grant  = (r_state == IDLE) & w_anyReq;
   end

   // State register.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. WAIT leaves when the counter is about to reach zero,
   // so CAPTURE lands exactly ROM_LAT cycles after the ISSUE cycle.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_nextState = ISSUE;
         ISSUE:   w_nextState = (ROM_LAT > 1) ? WAIT : CAPTURE;
         WAIT:    if (r_count <= 2'd1) w_nextState = CAPTURE;
         CAPTURE: w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Output logic driven from the state and the arbitration result.
   always_comb begin
      gnt0 = w_grant & ~w_winner;
      gnt1 = w_grant & w_winner;
      busy = (r_state != IDLE);
   end

   // Datapath. The ROM enable is set on the grant edge so it is high only
   // during ISSUE. The owner is remembered so the capture edge knows which
   // valid to pulse; a reset mid-access clears everything, which drops the
   // pending valid.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_romEna     <= 1'b0;
         r_romAddr    <= '0;
         r_owner      <= 1'b0;
         r_lastServed <= 1'b1;
         r_count      <= 2'd0;
         r_rdata      <= '0;
         r_vld0       <= 1'b0;
         r_vld1       <= 1'b0;
      end else begin
         r_romEna <= w_grant;
         if (w_grant) begin
            r_romAddr    <= w_winner ? addr1 : addr0;
            r_owner      <= w_winner;
            r_lastServed <= w_winner;
         end
         if (r_state == ISSUE) begin
            r_count <= LAT_LOAD;
         end else if (r_state == WAIT) begin
            r_count <= r_count - 2'd1;
         end
         if (r_state == CAPTURE) begin
            r_rdata <= rom_douta;
         end
         r_vld0 <= (r_state == CAPTURE) & ~r_owner;
         r_vld1 <= (r_state == CAPTURE) & r_owner;
      end
   end

   assign rom_ena   = r_romEna;
   assign rom_addra = r_romAddr;
   assign rdata     = r_rdata;
   assign vld0      = r_vld0;
   assign vld1      = r_vld1;

endmodule

// File: tb/tb_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_arbiter
// Two arbiters share the clock and reset: dutA with a one-cycle ROM and dutB
// with a three-cycle ROM. Each has its own behavioural ROM whose contents
// come from romWord(). Inputs change 1 ns after a rising edge and outputs
// are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rom_arbiter;

   localparam int LAT_A    = 1;
   localparam int LAT_B    = 3;
   localparam int RAND_CYC = 10000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        aReq0 = 1'b0, aReq1 = 1'b0;
   logic [3:0]  aAddr0 = 4'd0, aAddr1 = 4'd0;
   logic        aGnt0, aGnt1, aVld0, aVld1, aBusy, aRomEna;
   logic [3:0]  aRomAddr;
   logic [15:0] aRdata, aRomDout;

   logic        bReq0 = 1'b0, bReq1 = 1'b0;
   logic [3:0]  bAddr0 = 4'd0, bAddr1 = 4'd0;
   logic        bGnt0, bGnt1, bVld0, bVld1, bBusy, bRomEna;
   logic [3:0]  bRomAddr;
   logic [15:0] bRdata, bRomDout;
   logic [15:0] bPipe [3];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        r0;
      logic [3:0]  a0;
      logic        r1;
      logic [3:0]  a1;
      logic        g0;
      logic        g1;
      logic [3:0]  expAddr;
      logic [15:0] expData;
   } vec_t;

   typedef struct {
      int          due;
      logic        who;
      logic [15:0] data;
   } exp_t;

   always #5 clk = ~clk;

   rom_arbiter #(.ADDR_W(4), .DATA_W(16), .ROM_LAT(LAT_A)) dutA (
      .sys_clk(clk), .rst(rst),
      .req0(aReq0), .addr0(aAddr0), .gnt0(aGnt0), .vld0(aVld0),
      .req1(aReq1), .addr1(aAddr1), .gnt1(aGnt1), .vld1(aVld1),
      .rdata(aRdata), .busy(aBusy), .rom_ena(aRomEna),
      .rom_addra(aRomAddr), .rom_douta(aRomDout)
   );

   rom_arbiter #(.ADDR_W(4), .DATA_W(16), .ROM_LAT(LAT_B)) dutB (
      .sys_clk(clk), .rst(rst),
      .req0(bReq0), .addr0(bAddr0), .gnt0(bGnt0), .vld0(bVld0),
      .req1(bReq1), .addr1(bAddr1), .gnt1(bGnt1), .vld1(bVld1),
      .rdata(bRdata), .busy(bBusy), .rom_ena(bRomEna),
      .rom_addra(bRomAddr), .rom_douta(bRomDout)
   );

   // ROM contents: the named words plus an address-derived pattern elsewhere.
   function automatic logic [15:0] romWord(input logic [3:0] a);
      case (a)
         4'd2:    return 16'hAAAA;
         4'd3:    return 16'hBBBB;
         4'd5:    return 16'h1234;
         4'd15:   return 16'hF00F;
         default: return {a, ~a, a ^ 4'h5, 4'hC};
      endcase
   endfunction

   // One-cycle ROM for dutA.
   always @(posedge clk) begin
      if (aRomEna) aRomDout <= romWord(aRomAddr);
   end

   // Three-cycle ROM for dutB: read register followed by two delay stages.
   always @(posedge clk) begin
      if (bRomEna) bPipe[0] <= romWord(bRomAddr);
      bPipe[1] <= bPipe[0];
      bPipe[2] <= bPipe[1];
   end
   assign bRomDout = bPipe[2];

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checkWord(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      checkBit({tag, "_gnt0"}, aGnt0, 1'b0);
      checkBit({tag, "_gnt1"}, aGnt1, 1'b0);
      checkBit({tag, "_vld0"}, aVld0, 1'b0);
      checkBit({tag, "_vld1"}, aVld1, 1'b0);
      checkBit({tag, "_busy"}, aBusy, 1'b0);
      checkBit({tag, "_romEna"}, aRomEna, 1'b0);
      checkWord({tag, "_romAddr"}, 16'(aRomAddr), 16'h0);
      checkWord({tag, "_rdata"}, aRdata, 16'h0);
   endtask

   task automatic applyReset();
      stepCycle();
      rst = 1'b1;
      aReq0 = 1'b0; aReq1 = 1'b0; bReq0 = 1'b0; bReq1 = 1'b0;
      repeat (2) stepCycle();
      rst = 1'b0;
   endtask

   task automatic applyStimulus();
      vec_t vecs [6];
      exp_t sb [$];
      exp_t e;
      int   freeAt;
      logic lastServed;
      logic win, idle, expG0, expG1, expV0, expV1;
      logic [15:0] expD;

      // Reset behaviour with both requests high: nothing granted, all zero.
      aReq0 = 1'b1; aAddr0 = 4'd5; aReq1 = 1'b1; aAddr1 = 4'd3;
      @(negedge clk);
      checkOutput("rstHold0");
      @(negedge clk);
      checkOutput("rstHold1");
      applyReset();

      // Single transactions from idle; the round-robin pointer carries over.
      vecs[0] = '{1'b1, 4'd5, 1'b0, 4'd0,  1'b1, 1'b0, 4'd5,  16'h1234};
      vecs[1] = '{1'b1, 4'd2, 1'b1, 4'd3,  1'b0, 1'b1, 4'd3,  16'hBBBB};
      vecs[2] = '{1'b1, 4'd2, 1'b1, 4'd15, 1'b1, 1'b0, 4'd2,  16'hAAAA};
      vecs[3] = '{1'b0, 4'd0, 1'b1, 4'd15, 1'b0, 1'b1, 4'd15, 16'hF00F};
      vecs[4] = '{1'b0, 4'd9, 1'b1, 4'd0,  1'b0, 1'b1, 4'd0,  romWord(4'd0)};
      vecs[5] = '{1'b1, 4'd7, 1'b1, 4'd8,  1'b1, 1'b0, 4'd7,  romWord(4'd7)};
      for (int i = 0; i < 6; i++) begin
         stepCycle();
         aReq0 = vecs[i].r0; aAddr0 = vecs[i].a0;
         aReq1 = vecs[i].r1; aAddr1 = vecs[i].a1;
         @(negedge clk);
         checkBit($sformatf("vec%0d_gnt0", i), aGnt0, vecs[i].g0);
         checkBit($sformatf("vec%0d_gnt1", i), aGnt1, vecs[i].g1);
         stepCycle();
         aReq0 = 1'b0; aReq1 = 1'b0;
         @(negedge clk);
         checkBit($sformatf("vec%0d_romEna", i), aRomEna, 1'b1);
         checkWord($sformatf("vec%0d_romAddr", i), 16'(aRomAddr), 16'(vecs[i].expAddr));
         checkBit($sformatf("vec%0d_busy", i), aBusy, 1'b1);
         stepCycle();
         @(negedge clk);
         checkBit($sformatf("vec%0d_earlyVld", i), aVld0 | aVld1, 1'b0);
         checkBit($sformatf("vec%0d_enaLow", i), aRomEna, 1'b0);
         stepCycle();
         @(negedge clk);
         checkBit($sformatf("vec%0d_vld0", i), aVld0, vecs[i].g0);
         checkBit($sformatf("vec%0d_vld1", i), aVld1, vecs[i].g1);
         checkWord($sformatf("vec%0d_rdata", i), aRdata, vecs[i].expData);
         checkBit($sformatf("vec%0d_idle", i), aBusy, 1'b0);
      end

      // Both requesters held high from reset release: grants alternate.
      stepCycle();
      rst = 1'b1;
      repeat (2) stepCycle();
      aReq0 = 1'b1; aAddr0 = 4'd2; aReq1 = 1'b1; aAddr1 = 4'd3;
      stepCycle();
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) stepCycle();
         @(negedge clk);
         checkBit($sformatf("alt%0d_gnt0", c), aGnt0, (c % 6) == 0);
         checkBit($sformatf("alt%0d_gnt1", c), aGnt1, (c % 6) == 3);
         checkBit($sformatf("alt%0d_vld0", c), aVld0, (c % 6) == 3);
         checkBit($sformatf("alt%0d_vld1", c), aVld1, c >= 6 && (c % 6) == 0);
         checkBit($sformatf("alt%0d_romEna", c), aRomEna, (c % 3) == 1);
         if ((c % 6) == 3) checkWord($sformatf("alt%0d_rdata", c), aRdata, 16'hAAAA);
         if (c >= 6 && (c % 6) == 0) checkWord($sformatf("alt%0d_rdata", c), aRdata, 16'hBBBB);
      end

      // Requester 1 arrives during a requester-0 access.
      applyReset();
      aReq0 = 1'b1; aAddr0 = 4'd4;
      @(negedge clk);
      checkBit("late_gnt0", aGnt0, 1'b1);
      for (int c = 1; c < 7; c++) begin
         stepCycle();
         if (c == 1) begin aReq0 = 1'b0; aReq1 = 1'b1; aAddr1 = 4'd9; end
         if (c == 4) aReq1 = 1'b0;
         @(negedge clk);
         checkBit($sformatf("late%0d_gnt1", c), aGnt1, c == 3);
         checkBit($sformatf("late%0d_romEna", c), aRomEna, c == 1 || c == 4);
         checkBit($sformatf("late%0d_vld0", c), aVld0, c == 3);
         checkBit($sformatf("late%0d_vld1", c), aVld1, c == 6);
         if (c == 3) checkWord("late_rdata0", aRdata, romWord(4'd4));
         if (c == 6) checkWord("late_rdata1", aRdata, romWord(4'd9));
      end

      // Reset in the middle of an access drops it and restores priority.
      applyReset();
      aReq0 = 1'b1; aAddr0 = 4'd6;
      @(negedge clk);
      checkBit("abort_gnt0", aGnt0, 1'b1);
      stepCycle();
      aReq0 = 1'b0;
      stepCycle();
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abortRst0");
      stepCycle();
      @(negedge clk);
      checkOutput("abortRst1");
      stepCycle();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("abortAfter%0d", c));
         stepCycle();
      end
      aReq0 = 1'b1; aAddr0 = 4'd1; aReq1 = 1'b1; aAddr1 = 4'd2;
      @(negedge clk);
      checkBit("abortNext_gnt0", aGnt0, 1'b1);
      checkBit("abortNext_gnt1", aGnt1, 1'b0);
      stepCycle();
      aReq0 = 1'b0; aReq1 = 1'b0;
      repeat (2) stepCycle();
      @(negedge clk);
      checkBit("abortNext_vld0", aVld0, 1'b1);
      checkWord("abortNext_rdata", aRdata, romWord(4'd1));

      // Three-cycle ROM reading the top address.
      stepCycle();
      bReq1 = 1'b1; bAddr1 = 4'd15;
      @(negedge clk);
      checkBit("lat3_gnt1", bGnt1, 1'b1);
      checkBit("lat3_gnt0", bGnt0, 1'b0);
      for (int c = 1; c <= 5; c++) begin
         stepCycle();
         bReq1 = 1'b0;
         @(negedge clk);
         checkBit($sformatf("lat3_%0d_romEna", c), bRomEna, c == 1);
         checkBit($sformatf("lat3_%0d_vld1", c), bVld1, c == 5);
         checkBit($sformatf("lat3_%0d_vld0", c), bVld0, 1'b0);
         checkBit($sformatf("lat3_%0d_busy", c), bBusy, c < 5);
         if (c == 1) checkWord("lat3_romAddr", 16'(bRomAddr), 16'hF);
      end
      checkWord("lat3_rdata", bRdata, 16'hF00F);

      // Random traffic against a transaction-level model: an access granted
      // at cycle t completes at t+2+LAT, and that cycle is free again.
      applyReset();
      freeAt = 0;
      lastServed = 1'b1;
      expG0 = 1'b0; expG1 = 1'b0;
      for (int c = 0; c < RAND_CYC + 6; c++) begin
         stepCycle();
         if (c < RAND_CYC) begin
            if (aReq0 && expG0) begin
               if ($urandom_range(1, 0) == 1) aReq0 = 1'b0;
               else aAddr0 = 4'($urandom);
            end else if (!aReq0 && $urandom_range(9, 0) < 4) begin
               aReq0 = 1'b1; aAddr0 = 4'($urandom);
            end
            if (aReq1 && expG1) begin
               if ($urandom_range(1, 0) == 1) aReq1 = 1'b0;
               else aAddr1 = 4'($urandom);
            end else if (!aReq1 && $urandom_range(9, 0) < 4) begin
               aReq1 = 1'b1; aAddr1 = 4'($urandom);
            end
         end else begin
            aReq0 = 1'b0; aReq1 = 1'b0;
         end
         @(negedge clk);
         idle  = (c >= freeAt);
         expG0 = 1'b0; expG1 = 1'b0;
         if (idle && (aReq0 || aReq1)) begin
            win = (aReq0 && aReq1) ? ~lastServed : aReq1;
            expG0 = ~win; expG1 = win;
            e.due  = c + 2 + LAT_A;
            e.who  = win;
            e.data = romWord(win ? aAddr1 : aAddr0);
            sb.push_back(e);
            freeAt = c + 2 + LAT_A;
            lastServed = win;
         end
         expV0 = 1'b0; expV1 = 1'b0; expD = 16'h0;
         if (sb.size() > 0 && sb[0].due == c) begin
            e = sb.pop_front();
            expV0 = ~e.who; expV1 = e.who; expD = e.data;
         end
         checkBit($sformatf("rnd%0d_gnt0", c), aGnt0, expG0);
         checkBit($sformatf("rnd%0d_gnt1", c), aGnt1, expG1);
         checkBit($sformatf("rnd%0d_vld0", c), aVld0, expV0);
         checkBit($sformatf("rnd%0d_vld1", c), aVld1, expV1);
         checkBit($sformatf("rnd%0d_busy", c), aBusy, ~idle);
         if (expV0 || expV1) checkWord($sformatf("rnd%0d_rdata", c), aRdata, expD);
      end
      checkWord("rnd_sbEmpty", 16'(sb.size()), 16'h0);
   endtask

   initial begin
      applyStimulus();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
